// File: rtl/axi4_wr_responder.sv
// AXI4 INCR write responder: turns one AW/W burst into word writes on a flat memory port, then a B response.
// Latency: mem write registered one cycle after each W beat; B valid the cycle after the burst's final beat.
// Backpressure: one burst outstanding; AW/W/B ready follow IDLE/DATA/RESP, B held until bready. Option: AXI4_WR_RESPONDER_ERR_CNT_EN.
module axi4_wr_responder #(
    parameter int DSIZE  = 32,
    parameter int IDSIZE = 2,
    parameter int ASIZE  = 8,
    parameter int LSIZE  = 9,
    parameter int DEPTH  = 64
) (
    input  logic                     clock,
    input  logic                     rst_n,
    input  logic [IDSIZE-1:0]        axi_awid,
    input  logic [ASIZE-1:0]         axi_awaddr,
    input  logic [LSIZE-1:0]         axi_awlen,
    input  logic                     axi_awvalid,
    output logic                     axi_awready,
    input  logic [DSIZE-1:0]         axi_wdata,
    input  logic [DSIZE/8-1:0]       axi_wstrb,
    input  logic                     axi_wlast,
    input  logic                     axi_wvalid,
    output logic                     axi_wready,
    output logic [IDSIZE-1:0]        axi_bid,
    output logic [1:0]               axi_bresp,
    output logic                     axi_bvalid,
    input  logic                     axi_bready,
    output logic                     mem_wr_en,
    output logic [$clog2(DEPTH)-1:0] mem_addr,
    output logic [DSIZE-1:0]         mem_wdata,
    output logic [DSIZE/8-1:0]       mem_wstrb
`ifdef AXI4_WR_RESPONDER_ERR_CNT_EN
    ,
    output logic [15:0]              err_cnt
`endif
);

    localparam int BW  = DSIZE / 8;
    localparam int AW  = $clog2(DEPTH);
    localparam int OFS = $clog2(BW);
    // Pointer must hold any start word and the saturation value DEPTH itself.
    localparam int PW  = (ASIZE > AW + 1) ? ASIZE : AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_RESP} state_t;

    state_t            state_q, state_d;
    logic [IDSIZE-1:0] id_q, id_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [LSIZE-1:0]  cnt_q, cnt_d;
    logic              dec_err_q, dec_err_d;
    logic              prot_err_q, prot_err_d;
    logic              wr_en_q, wr_en_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [DSIZE-1:0]  wdata_q, wdata_d;
    logic [BW-1:0]     wstrb_q, wstrb_d;

    logic in_range;
    logic w_hs;
    logic b_hs;

    assign axi_awready = (state_q == S_IDLE);
    assign axi_wready  = (state_q == S_DATA);
    assign axi_bvalid  = (state_q == S_RESP);
    assign axi_bid     = id_q;
    assign in_range    = (ptr_q < PW'(DEPTH));
    assign w_hs        = axi_wvalid && axi_wready;
    assign b_hs        = axi_bvalid && axi_bready;

    assign mem_wr_en   = wr_en_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign mem_wstrb   = wstrb_q;

    always_comb begin
        axi_bresp = 2'b00;
        if (state_q == S_RESP) begin
            if (dec_err_q)       axi_bresp = 2'b11;
            else if (prot_err_q) axi_bresp = 2'b10;
        end
    end

    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        dec_err_d  = dec_err_q;
        prot_err_d = prot_err_q;
        wr_en_d    = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        case (state_q)
            S_IDLE: begin
                if (axi_awvalid) begin
                    id_d       = axi_awid;
                    ptr_d      = PW'(axi_awaddr >> OFS);
                    cnt_d      = axi_awlen;
                    dec_err_d  = 1'b0;
                    prot_err_d = 1'b0;
                    state_d    = S_DATA;
                end
            end
            S_DATA: begin
                if (w_hs) begin
                    if (in_range) begin
                        wr_en_d = 1'b1;
                        addr_d  = ptr_q[AW-1:0];
                        wdata_d = axi_wdata;
                        wstrb_d = axi_wstrb;
                        ptr_d   = ptr_q + 1'b1;
                    end else begin
                        dec_err_d = 1'b1;
                    end
                    // wlast must coincide exactly with the final counted beat.
                    if (axi_wlast != (cnt_q == '0)) prot_err_d = 1'b1;
                    if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
                    if (axi_wlast || (cnt_q == '0)) state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (axi_bready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            id_q       <= '0;
            ptr_q      <= '0;
            cnt_q      <= '0;
            dec_err_q  <= 1'b0;
            prot_err_q <= 1'b0;
            wr_en_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
        end else begin
            state_q    <= state_d;
            id_q       <= id_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            dec_err_q  <= dec_err_d;
            prot_err_q <= prot_err_d;
            wr_en_q    <= wr_en_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
        end
    end

`ifdef AXI4_WR_RESPONDER_ERR_CNT_EN
    logic [15:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (b_hs && (axi_bresp != 2'b00) && (err_cnt_q != 16'hFFFF))
            err_cnt_d = err_cnt_q + 16'd1;
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) err_cnt_q <= 16'd0;
        else        err_cnt_q <= err_cnt_d;
    end

    assign err_cnt = err_cnt_q;
`else
    // Without the error counter the B handshake has no extra consumer.
    logic unused_b_hs;
    assign unused_b_hs = b_hs;
`endif

endmodule

// File: tb/tb_axi4_wr_responder.sv
// Bench for axi4_wr_responder: directed burst table, reset-mid-burst sequence, randomized bursts vs. a burst-level model.
module tb_axi4_wr_responder;

    logic        clock;
    logic        rst_n;
    logic [1:0]  axi_awid;
    logic [7:0]  axi_awaddr;
    logic [8:0]  axi_awlen;
    logic        axi_awvalid;
    logic        axi_awready;
    logic [31:0] axi_wdata;
    logic [3:0]  axi_wstrb;
    logic        axi_wlast;
    logic        axi_wvalid;
    logic        axi_wready;
    logic [1:0]  axi_bid;
    logic [1:0]  axi_bresp;
    logic        axi_bvalid;
    logic        axi_bready;
    logic        mem_wr_en;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
`ifdef AXI4_WR_RESPONDER_ERR_CNT_EN
    logic [15:0] err_cnt;
`endif

    axi4_wr_responder #(
        .DSIZE(32), .IDSIZE(2), .ASIZE(8), .LSIZE(9), .DEPTH(64)
    ) dut (
        .clock(clock), .rst_n(rst_n),
        .axi_awid(axi_awid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
        .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
        .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid),
        .axi_bready(axi_bready),
        .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb)
`ifdef AXI4_WR_RESPONDER_ERR_CNT_EN
        , .err_cnt(err_cnt)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_fail = 0;
    int wr_pulses = 0;

    always @(negedge clock) if (mem_wr_en === 1'b1) wr_pulses++;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [1:0]  id;
        logic [7:0]  addr;
        int          len;
        int          last_at;
        int          bdly;
        logic [31:0] dbase;
        logic [3:0]  strb;
        bit          overlap;
        logic [1:0]  exp_resp;
        int          exp_nwr;
    } vec_t;

    // Burst-level reference: response code and number of in-range words written.
    function automatic logic [1:0] model_resp(input logic [7:0] addr, input int len, input int last_at);
        int word = int'(addr) / 4;
        int nb   = ((last_at < len) ? last_at : len) + 1;
        if (word + nb - 1 >= 64) return 2'd3;
        if (last_at != len)      return 2'd2;
        return 2'd0;
    endfunction

    function automatic int model_nwr(input logic [7:0] addr, input int len, input int last_at);
        int word = int'(addr) / 4;
        int nb   = ((last_at < len) ? last_at : len) + 1;
        int room = 64 - word;
        if (room < 0) room = 0;
        return (nb < room) ? nb : room;
    endfunction

    task automatic wait_sig(input string name, input int which);
        int t = 0;
        while (t < 20 && ((which == 0) ? axi_awready !== 1'b1 :
                          (which == 1) ? axi_wready  !== 1'b1 : axi_bvalid !== 1'b1)) begin
            @(negedge clock);
            t++;
        end
        if (t == 20) chk({name, "_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic run_burst(input logic [1:0] id, input logic [7:0] addr, input int len,
                             input int last_at, input int bdly, input logic [31:0] dbase,
                             input logic [3:0] strb, input bit overlap, input bit gaps,
                             input logic [1:0] exp_resp, input int exp_nwr);
        int word = int'(addr) / 4;
        int nb   = ((last_at < len) ? last_at : len) + 1;
        int start_wr;
        @(negedge clock);
        start_wr    = wr_pulses;
        axi_awid    = id;
        axi_awaddr  = addr;
        axi_awlen   = 9'(len);
        axi_awvalid = 1'b1;
        if (overlap) begin
            axi_wvalid = 1'b1;
            axi_wdata  = dbase;
            axi_wstrb  = strb;
            axi_wlast  = (last_at == 0);
        end
        wait_sig("aw", 0);
        @(posedge clock);
        @(negedge clock);
        axi_awvalid = 1'b0;
        chk("awready_after_aw", {31'd0, axi_awready}, 32'd0);
        for (int i = 0; i < nb; i++) begin
            if (gaps && !(overlap && i == 0) && $urandom_range(0, 2) == 0) begin
                axi_wvalid = 1'b0;
                @(negedge clock);
                chk("wr_en_idle_gap", {31'd0, mem_wr_en}, 32'd0);
            end
            axi_wvalid = 1'b1;
            axi_wdata  = dbase + 32'(i);
            axi_wstrb  = strb;
            axi_wlast  = (i == last_at);
            wait_sig("w", 1);
            @(posedge clock);
            @(negedge clock);
            axi_wvalid = 1'b0;
            axi_wlast  = 1'b0;
            chk("mem_wr_en", {31'd0, mem_wr_en}, {31'd0, (word + i < 64)});
            if (word + i < 64) begin
                chk("mem_addr",  {26'd0, mem_addr}, 32'(word + i));
                chk("mem_wdata", mem_wdata, dbase + 32'(i));
                chk("mem_wstrb", {28'd0, mem_wstrb}, {28'd0, strb});
            end
            chk("wready_after_beat", {31'd0, axi_wready}, {31'd0, (i != nb - 1)});
        end
        wait_sig("b", 2);
        chk("bvalid", {31'd0, axi_bvalid}, 32'd1);
        chk("bid",    {30'd0, axi_bid},    {30'd0, id});
        chk("bresp",  {30'd0, axi_bresp},  {30'd0, exp_resp});
        for (int k = 0; k < bdly; k++) begin
            @(negedge clock);
            chk("bvalid_held", {31'd0, axi_bvalid}, 32'd1);
            chk("bid_held",    {30'd0, axi_bid},    {30'd0, id});
            chk("bresp_held",  {30'd0, axi_bresp},  {30'd0, exp_resp});
            chk("wready_in_resp", {31'd0, axi_wready}, 32'd0);
        end
        axi_bready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        axi_bready = 1'b0;
        chk("bvalid_after_b", {31'd0, axi_bvalid},  32'd0);
        chk("awready_after_b", {31'd0, axi_awready}, 32'd1);
        chk("write_count", 32'(wr_pulses - start_wr), 32'(exp_nwr));
    endtask

    task automatic run_vec(input vec_t v, input bit gaps);
        run_burst(v.id, v.addr, v.len, v.last_at, v.bdly, v.dbase, v.strb, v.overlap,
                  gaps, v.exp_resp, v.exp_nwr);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_awready"}, {31'd0, axi_awready}, 32'd1);
        chk({tag, "_wready"},  {31'd0, axi_wready},  32'd0);
        chk({tag, "_bvalid"},  {31'd0, axi_bvalid},  32'd0);
        chk({tag, "_bresp"},   {30'd0, axi_bresp},   32'd0);
        chk({tag, "_bid"},     {30'd0, axi_bid},     32'd0);
        chk({tag, "_wr_en"},   {31'd0, mem_wr_en},   32'd0);
        chk({tag, "_addr"},    {26'd0, mem_addr},    32'd0);
        chk({tag, "_wdata"},   mem_wdata,            32'd0);
        chk({tag, "_wstrb"},   {28'd0, mem_wstrb},   32'd0);
    endtask

    vec_t tbl [8];

    initial begin
        tbl[0] = '{2'd1, 8'h10, 3, 3, 0, 32'hA0, 4'hF, 1'b0, 2'd0, 4};
        tbl[1] = '{2'd2, 8'h00, 0, 0, 5, 32'h55, 4'h3, 1'b0, 2'd0, 1};
        tbl[2] = '{2'd3, 8'hF8, 3, 3, 1, 32'hC0, 4'hF, 1'b0, 2'd3, 2};
        tbl[3] = '{2'd0, 8'h20, 3, 1, 0, 32'hD0, 4'h5, 1'b0, 2'd2, 2};
        tbl[4] = '{2'd1, 8'hFC, 0, 0, 2, 32'hE0, 4'h8, 1'b0, 2'd0, 1};
        tbl[5] = '{2'd2, 8'h40, 1, 5, 0, 32'h11, 4'hF, 1'b0, 2'd2, 2};
        tbl[6] = '{2'd3, 8'h03, 1, 1, 0, 32'h22, 4'hA, 1'b1, 2'd0, 2};
        tbl[7] = '{2'd0, 8'hFC, 3, 1, 3, 32'h33, 4'hF, 1'b0, 2'd3, 1};

        rst_n = 1'b0;
        axi_awid = '0; axi_awaddr = '0; axi_awlen = '0; axi_awvalid = 1'b0;
        axi_wdata = '0; axi_wstrb = '0; axi_wlast = 1'b0; axi_wvalid = 1'b0;
        axi_bready = 1'b0;
        #1;
        chk_reset_outputs("reset");
`ifdef AXI4_WR_RESPONDER_ERR_CNT_EN
        chk("reset_err_cnt", {16'd0, err_cnt}, 32'd0);
`endif
        repeat (3) @(negedge clock);
        rst_n = 1'b1;
        @(negedge clock);
        chk_reset_outputs("post_reset");

        for (int i = 0; i < 8; i++) run_vec(tbl[i], 1'b0);

        // Reset lands mid-burst, right while a write pulse is on the memory port.
        @(negedge clock);
        axi_awid = 2'd2; axi_awaddr = 8'h20; axi_awlen = 9'd7; axi_awvalid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        axi_awvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            axi_wvalid = 1'b1; axi_wdata = 32'hF0 + 32'(i); axi_wstrb = 4'hF; axi_wlast = 1'b0;
            @(posedge clock);
            @(negedge clock);
        end
        axi_wvalid = 1'b0;
        chk("mid_burst_wr_en", {31'd0, mem_wr_en}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_outputs("async_reset");
        @(negedge clock);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            chk("no_b_after_reset", {31'd0, axi_bvalid}, 32'd0);
            chk("wready_after_reset", {31'd0, axi_wready}, 32'd0);
        end
        run_burst(2'd1, 8'h08, 2, 2, 0, 32'h70, 4'hF, 1'b0, 1'b0, 2'd0, 3);

        for (int r = 0; r < 24; r++) begin
            logic [1:0] id;
            logic [7:0] addr;
            int len, last_at;
            id   = 2'($urandom_range(0, 3));
            addr = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(224, 255)) : 8'($urandom_range(0, 255));
            len  = $urandom_range(0, 7);
            last_at = ($urandom_range(0, 9) < 7) ? len : $urandom_range(0, len + 2);
            run_burst(id, addr, len, last_at, $urandom_range(0, 3), $urandom, 4'($urandom_range(0, 15)),
                      1'($urandom_range(0, 1)), 1'b1,
                      model_resp(addr, len, last_at), model_nwr(addr, len, last_at));
        end

`ifdef AXI4_WR_RESPONDER_ERR_CNT_EN
        @(negedge clock);
        rst_n = 1'b0;
        @(negedge clock);
        rst_n = 1'b1;
        chk("err_cnt_cleared", {16'd0, err_cnt}, 32'd0);
        run_vec(tbl[2], 1'b0);
        run_vec(tbl[3], 1'b0);
        chk("err_cnt_two_errors", {16'd0, err_cnt}, 32'd2);
        run_vec(tbl[0], 1'b0);
        chk("err_cnt_after_okay", {16'd0, err_cnt}, 32'd2);
`endif

        repeat (2) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
